gate_op_arbiter: RTL and testbench
==================================

Name: gate_op_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) among 4 requesters.
- Round-robin arbitration with a 3-state FSM; operands are captured at grant and the result is registered.
- Sits between requester blocks and the library's combinational gate cells. It is the sequencing layer above the per-gate modules.

Parameters:
WIDTH, 8, operand/result width in bits
N_REQ, 4, number of requesters (fixed at 4; ID width 2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
req  input  4  req[i]=1: requester i has a pending operation
op  input  8  op[2i+1:2i] = opcode of requester i: 00 AND, 01 OR, 10 XOR, 11 NAND
in1  input  4*WIDTH  operand A; slice i = in1[i*WIDTH +: WIDTH]
in2  input  4*WIDTH  operand B; same slicing as in1
gnt  output  4  one-hot grant, high exactly one cycle per accepted request
out  output  WIDTH  registered result of the last operation
out_valid  output  1  one-cycle pulse: out/out_id valid
out_id  output  2  index of the requester that owns out
busy  output  1  high while FSM not IDLE

Behaviour:
- Reset (sync, rst=1 at rising edge): state=IDLE, ptr=0, gnt=0, out=0, out_valid=0, out_id=0, busy=0. Reset overrides all, including mid-operation. An in-flight op is dropped with no out_valid and no re-grant.
- FSM states: IDLE, EXEC, DONE.
- IDLE, req==0: stay; outputs gnt=0, out_valid=0.
- IDLE, req!=0: select winner = first i with req[i]=1 searching ptr, ptr+1, ... mod 4.
  - Capture in1/in2/op slices of the winner and store id=winner.
  - Go to EXEC.
- EXEC:
  - gnt[id]=1 (only bit set); busy=1.
  - Compute the result from the captured operands; register it into out at the end of the cycle.
  - Go to DONE.
- DONE:
  - out_valid=1; out_id=id; busy=1.
  - ptr<=id+1 (mod 4, wraps 3->0).
  - Go to IDLE.
- Latency: req sampled at edge k, gnt high cycle k+1, out_valid high cycle k+2. Max throughput: 1 op / 3 cycles.
- Requester contract:
  - Hold req and operands stable until gnt seen.
  - Deassert req the cycle after gnt unless a new op is pending.
  - req during EXEC/DONE is ignored; it is not lost, and is resampled in IDLE.
- Operands are captured only in IDLE. Changes to in1/in2/op after capture do not affect the result.
- out holds its value between operations. out_id holds between operations. out_valid and gnt are pulses.
- Arithmetic: pure bitwise, WIDTH bits, no carry or overflow.
  - AND: out = a & b.
  - OR: out = a | b.
  - XOR: out = a ^ b.
  - NAND: out = ~(a & b).
- Fairness: a continuously requesting requester is granted within 4 grants.
- Simultaneous requests: resolved solely by the ptr rotation; no fixed priority except after reset (ptr=0 favours 0).
- gnt and out_valid are never high in the same cycle.

Test Plan:
- Reset then req=0001, op[1:0]=00, in1[7:0]=8'b00110011, in2[7:0]=8'b11001100 -> gnt=0001 at cycle+1; out_valid=1, out_id=0, out=8'h00 at cycle+2; busy high for 2 cycles.
- req=0010, op[3:2]=01, in1 slice1=8'hAA, in2 slice1=8'hF0 -> out=8'hFA, out_id=1. Repeat with op=10 -> 8'h5A; with op=11 -> 8'h5F.
- req=1111 held continuously from reset, distinct ops -> grant order 0,1,2,3,0, one grant every 3 cycles; each out_id matches the preceding gnt.
- After a grant to requester 1 (ptr=2), present req=1001 -> requester 3 is granted before 0, then 0 on the next arbitration.
- Change in1 slice0 from 8'h0F to 8'hFF during EXEC of an AND with in2=8'h3C -> out=8'h0C (captured value used).
- Assert rst during EXEC -> next cycle: gnt=0, out_valid=0, out=0, busy=0, state IDLE, ptr=0.
  - No out_valid follows.
  - With req=0001 still held, requester 0 is re-granted 1 cycle after rst drops.

Source files
------------

// File: rtl/gate_op_arbiter_if.sv
// ---------------------------------------------------------------------------
// gate_op_arbiter_if
// Handshake/data bundle between requester blocks and the shared gate-op
// arbiter.
//   master : requester side, drives req/op/in1/in2 and observes the results
//   slave  : arbiter side, drives gnt/out/out_valid/out_id/busy
// Signals
//   req       [N_REQ]        per-requester pending operation
//   op        [2*N_REQ]      opcode per requester (00 AND, 01 OR, 10 XOR, 11 NAND)
//   in1/in2   [N_REQ*WIDTH]  operand A/B, slice i = [i*WIDTH +: WIDTH]
//   gnt       [N_REQ]        one-hot grant pulse
//   out       [WIDTH]        registered result, held between operations
//   out_valid                one-cycle result strobe
//   out_id    [2]            owner of out
//   busy                     arbiter not idle
// ---------------------------------------------------------------------------
interface gate_op_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [N_REQ*WIDTH-1:0] in1;
    logic [N_REQ*WIDTH-1:0] in2;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       out;
    logic                   out_valid;
    logic [1:0]             out_id;
    logic                   busy;

    modport master (
        output req, op, in1, in2,
        input  gnt, out, out_valid, out_id, busy
    );

    modport slave (
        input  req, op, in1, in2,
        output gnt, out, out_valid, out_id, busy
    );
endinterface

// File: rtl/gate_op_arbiter.sv
// ---------------------------------------------------------------------------
// gate_op_arbiter
// Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) among 4
// requesters using round-robin arbitration and a 3-state FSM
// (IDLE -> EXEC -> DONE). Operands are captured when the winner is picked
// in IDLE; the result is registered at the end of EXEC.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gate_op_arbiter_if.slave (req/op/in1/in2 in, gnt/out/out_valid/
//          out_id/busy out)
// Timing: req sampled at edge k -> gnt in cycle k+1 -> out_valid in cycle k+2.
// ---------------------------------------------------------------------------
module gate_op_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    gate_op_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [1:0]         r_id;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_out;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_out_valid;
    logic [1:0]         r_out_id;

    logic               w_any;
    logic [1:0]         w_win;
    logic [WIDTH-1:0]   w_res;

    // Rotating search starting at r_ptr; 2-bit index arithmetic wraps 3->0.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any && bus.req[r_ptr + 2'(k)]) begin
                w_any = 1'b1;
                w_win = r_ptr + 2'(k);
            end
        end
    end

    // Shared logic unit, fed only from the captured operands.
    always_comb begin
        w_res = '0;
        case (r_op)
            2'b00:   w_res = r_a & r_b;
            2'b01:   w_res = r_a | r_b;
            2'b10:   w_res = r_a ^ r_b;
            default: w_res = ~(r_a & r_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_id        <= 2'd0;
            r_op        <= 2'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gnt       <= '0;
                    r_out_valid <= 1'b0;
                    if (w_any) begin
                        r_a     <= bus.in1[int'(w_win)*WIDTH +: WIDTH];
                        r_b     <= bus.in2[int'(w_win)*WIDTH +: WIDTH];
                        r_op    <= bus.op[{w_win, 1'b0} +: 2];
                        r_id    <= w_win;
                        // Grant is registered so it is visible during EXEC.
                        r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_gnt       <= '0;
                    r_out       <= w_res;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_out_valid <= 1'b0;
                    r_ptr       <= r_id + 2'd1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_id    = r_out_id;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_gate_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gate_op_arbiter
// Directed scenarios from the block's behaviour plus a randomized run checked
// against a behavioural model (rotating-pointer winner, bitwise result).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gate_op_arbiter;
    logic clk;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    gate_op_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus();

    gate_op_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic set_slot(input int i, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        bus.op[2*i +: 2] = o;
        bus.in1[i*8 +: 8] = a;
        bus.in2[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        vecs++; if (bus.out !== 8'h00) begin errs++; $display("FAIL reset_out: got %h expected 00", bus.out); end
        vecs++; if (bus.out_id !== 2'd0) begin errs++; $display("FAIL reset_out_id: got %0d expected 0", bus.out_id); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_basic_ops();
        logic [7:0] exp_tab [4];
        exp_tab[1] = 8'hFA; exp_tab[2] = 8'h5A; exp_tab[3] = 8'h5F;
        set_slot(0, 2'b00, 8'b00110011, 8'b11001100);
        bus.req = 4'b0001;
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0001) begin errs++; $display("FAIL basic_gnt: got %b expected 0001", bus.gnt); end
        vecs++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL basic_exec: busy %b out_valid %b expected 1 0", bus.busy, bus.out_valid); end
        bus.req = 4'b0000;
        @(negedge clk);
        vecs++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out !== 8'h00) begin
            errs++; $display("FAIL basic_and: out_valid %b id %0d out %h expected 1 0 00", bus.out_valid, bus.out_id, bus.out); end
        vecs++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin errs++; $display("FAIL basic_done: gnt %b busy %b expected 0000 1", bus.gnt, bus.busy); end
        @(negedge clk);
        vecs++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out !== 8'h00) begin
            errs++; $display("FAIL basic_idle: busy %b out_valid %b out %h expected 0 0 00", bus.busy, bus.out_valid, bus.out); end
        for (int o = 1; o < 4; o++) begin
            set_slot(1, 2'(o), 8'hAA, 8'hF0);
            bus.req = 4'b0010;
            @(negedge clk);
            vecs++; if (bus.gnt !== 4'b0010) begin errs++; $display("FAIL op%0d_gnt: got %b expected 0010", o, bus.gnt); end
            bus.req = 4'b0000;
            @(negedge clk);
            vecs++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out !== exp_tab[o]) begin
                errs++; $display("FAIL op%0d_result: out_valid %b id %0d out %h expected 1 1 %h", o, bus.out_valid, bus.out_id, bus.out, exp_tab[o]); end
            @(negedge clk);
        end
    endtask

    // Entered with the pointer at 2 (last grant went to requester 1).
    task automatic test_ptr_rotation();
        logic [7:0] a0, b0, a3, b3;
        a0 = 8'($urandom); b0 = 8'($urandom); a3 = 8'($urandom); b3 = 8'($urandom);
        set_slot(0, 2'd2, a0, b0);
        set_slot(3, 2'd1, a3, b3);
        bus.req = 4'b1001;
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b1000) begin errs++; $display("FAIL ptr_first_gnt: got %b expected 1000", bus.gnt); end
        bus.req = 4'b0001;
        @(negedge clk);
        vecs++; if (bus.out_id !== 2'd3 || bus.out !== (a3 | b3)) begin
            errs++; $display("FAIL ptr_first_out: id %0d out %h expected 3 %h", bus.out_id, bus.out, a3 | b3); end
        @(negedge clk);
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0001) begin errs++; $display("FAIL ptr_second_gnt: got %b expected 0001", bus.gnt); end
        bus.req = 4'b0000;
        @(negedge clk);
        vecs++; if (bus.out_id !== 2'd0 || bus.out !== (a0 ^ b0)) begin
            errs++; $display("FAIL ptr_second_out: id %0d out %h expected 0 %h", bus.out_id, bus.out, a0 ^ b0); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [7:0] a [4];
        logic [7:0] b [4];
        int exp_id;
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'($urandom); b[i] = 8'($urandom);
            set_slot(i, 2'(i), a[i], b[i]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % 4;
            @(negedge clk);
            vecs++; if (bus.gnt !== (4'b0001 << exp_id)) begin errs++; $display("FAIL rr_gnt%0d: got %b expected %b", g, bus.gnt, 4'b0001 << exp_id); end
            if (g == 4) bus.req = 4'b0000;
            @(negedge clk);
            vecs++; if (bus.out_valid !== 1'b1 || bus.gnt !== 4'b0000 || bus.out_id !== 2'(exp_id) || bus.out !== ref_op(2'(exp_id), a[exp_id], b[exp_id])) begin
                errs++; $display("FAIL rr_out%0d: out_valid %b gnt %b id %0d out %h expected 1 0000 %0d %h", g, bus.out_valid, bus.gnt, bus.out_id, bus.out, exp_id, ref_op(2'(exp_id), a[exp_id], b[exp_id])); end
            @(negedge clk);
            vecs++; if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0) begin
                errs++; $display("FAIL rr_gap%0d: gnt %b out_valid %b expected 0000 0", g, bus.gnt, bus.out_valid); end
        end
    endtask

    task automatic test_capture();
        set_slot(0, 2'b00, 8'h0F, 8'h3C);
        bus.req = 4'b0001;
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0001) begin errs++; $display("FAIL capture_gnt: got %b expected 0001", bus.gnt); end
        bus.in1[7:0] = 8'hFF;
        bus.req = 4'b0000;
        @(negedge clk);
        vecs++; if (bus.out !== 8'h0C) begin errs++; $display("FAIL capture_out: got %h expected 0c", bus.out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_slot(0, 2'b11, 8'hC3, 8'h81);
        bus.req = 4'b0001;
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0001) begin errs++; $display("FAIL rstmid_gnt: got %b expected 0001", bus.gnt); end
        rst = 1'b1;
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.busy !== 1'b0 || bus.out_id !== 2'd0) begin
            errs++; $display("FAIL rstmid_clear: gnt %b out_valid %b out %h busy %b id %0d expected 0000 0 00 0 0", bus.gnt, bus.out_valid, bus.out, bus.busy, bus.out_id); end
        rst = 1'b0;
        @(negedge clk);
        vecs++; if (bus.gnt !== 4'b0001 || bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL rstmid_regrant: gnt %b out_valid %b expected 0001 0", bus.gnt, bus.out_valid); end
        bus.req = 4'b0000;
        @(negedge clk);
        vecs++; if (bus.out_valid !== 1'b1 || bus.out !== 8'h7E) begin
            errs++; $display("FAIL rstmid_out: out_valid %b out %h expected 1 7e", bus.out_valid, bus.out); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int         mptr;
        int         win;
        logic [3:0] reqv;
        logic [7:0] ea, eb, last_out;
        logic [1:0] eo;
        do_reset();
        mptr = 0;
        last_out = 8'h00;
        for (int n = 0; n < 150; n++) begin
            bus.in1 = $urandom;
            bus.in2 = $urandom;
            bus.op  = 8'($urandom);
            reqv    = 4'($urandom_range(0, 15));
            bus.req = reqv;
            win = -1;
            for (int j = 0; j < 4; j++)
                if (win < 0 && reqv[(mptr + j) % 4]) win = (mptr + j) % 4;
            @(negedge clk);
            if (win < 0) begin
                vecs++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.out !== last_out) begin
                    errs++; $display("FAIL rand%0d_idle: gnt %b busy %b out %h expected 0000 0 %h", n, bus.gnt, bus.busy, bus.out, last_out); end
                continue;
            end
            ea = bus.in1[win*8 +: 8];
            eb = bus.in2[win*8 +: 8];
            eo = bus.op[2*win +: 2];
            vecs++; if (bus.gnt !== (4'b0001 << win)) begin errs++; $display("FAIL rand%0d_gnt: req %b got %b expected %b", n, reqv, bus.gnt, 4'b0001 << win); end
            // Requests and operands seen outside IDLE must not matter.
            bus.in1 = $urandom; bus.in2 = $urandom; bus.op = 8'($urandom); bus.req = 4'($urandom);
            @(negedge clk);
            last_out = ref_op(eo, ea, eb);
            vecs++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'(win) || bus.out !== last_out) begin
                errs++; $display("FAIL rand%0d_out: out_valid %b id %0d out %h expected 1 %0d %h", n, bus.out_valid, bus.out_id, bus.out, win, last_out); end
            bus.req = 4'($urandom);
            mptr = (win + 1) % 4;
            @(negedge clk);
        end
        bus.req = 4'b0000;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.op  = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        test_reset();
        test_basic_ops();
        test_ptr_rotation();
        test_round_robin();
        test_capture();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
